// File: rtl/lcd_char_writer.sv
// HD44780 16x2 writer: power-up init, then continuous refresh of a 32-char index/char buffer.
// Define LCD_NONPRINT_FILTER_EN to replace captured characters outside 0x20..0x7E with a space.
module lcd_char_writer #(
   parameter int POWERUP_CYC = 750000,
   parameter int E_PULSE_CYC = 12,
   parameter int CMD_CYC     = 2500,
   parameter int CLR_CYC     = 100000,
   parameter int FETCH_LAT   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] char_in,
   output logic [4:0] index,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data,
   output logic       init_done,
   output logic       frame_done
);

   localparam int MAX_A   = (POWERUP_CYC > CLR_CYC) ? POWERUP_CYC : CLR_CYC;
   localparam int MAX_B   = (CMD_CYC > E_PULSE_CYC) ? CMD_CYC : E_PULSE_CYC;
   localparam int MAX_C   = (MAX_B > FETCH_LAT) ? MAX_B : FETCH_LAT;
   localparam int MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   typedef enum logic [2:0] {S_PWRUP, S_FETCH, S_SETUP, S_EHIGH, S_WAIT} state_t;

   state_t           r_state, w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_dur;
   logic             w_last;
   logic [1:0]       r_init_ptr;
   logic             r_init_done;
   logic [5:0]       r_seq;          // refresh step: 0=0x80, 1..16 line 1, 17=0xC0, 18..33 line 2
   logic [5:0]       w_seq_next;
   logic             w_next_char;
   logic [4:0]       w_char_idx;
   logic [7:0]       w_cmd_next;
   logic [7:0]       w_char_f;
   logic [4:0]       r_index;
   logic [7:0]       r_data;
   logic             r_rs;
   logic             r_frame_done;
   logic             w_is_clear;

   function automatic logic [7:0] init_cmd(input logic [1:0] ptr);
      case (ptr)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h06;
         default: return 8'h01;
      endcase
   endfunction

`ifdef LCD_NONPRINT_FILTER_EN
   assign w_char_f = (char_in < 8'h20 || char_in > 8'h7E) ? 8'h20 : char_in;
`else
   assign w_char_f = char_in;
`endif

   assign w_is_clear  = !r_rs && (r_data == 8'h01);
   assign w_seq_next  = (r_seq == 6'd33) ? 6'd0 : r_seq + 6'd1;
   assign w_next_char = r_init_done && (w_seq_next != 6'd0) && (w_seq_next != 6'd17);
   assign w_char_idx  = (w_seq_next < 6'd17) ? w_seq_next[4:0] - 5'd1 : w_seq_next[4:0] - 5'd2;

   always_comb begin
      w_dur = CNT_W'(1);
      case (r_state)
         S_PWRUP: w_dur = CNT_W'(POWERUP_CYC);
         S_FETCH: w_dur = CNT_W'(FETCH_LAT);
         S_SETUP: w_dur = CNT_W'(1);
         S_EHIGH: w_dur = CNT_W'(E_PULSE_CYC);
         S_WAIT:  w_dur = w_is_clear ? CNT_W'(CLR_CYC) : CNT_W'(CMD_CYC);
         default: w_dur = CNT_W'(1);
      endcase
   end
   assign w_last = (r_cnt == w_dur - CNT_W'(1));

   always_comb begin
      if (r_state == S_PWRUP)
         w_cmd_next = init_cmd(2'd0);
      else if (!r_init_done)
         w_cmd_next = (r_init_ptr == 2'd3) ? 8'h80 : init_cmd(r_init_ptr + 2'd1);
      else
         w_cmd_next = (w_seq_next == 6'd17) ? 8'hC0 : 8'h80;
   end

   // State register; the counter restarts from zero on every state change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_PWRUP;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= (w_state_next != r_state) ? '0 : r_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_PWRUP: if (w_last) w_state_next = S_SETUP;
         S_FETCH: if (w_last) w_state_next = S_SETUP;
         S_SETUP: if (w_last) w_state_next = S_EHIGH;
         S_EHIGH: if (w_last) w_state_next = S_WAIT;
         S_WAIT:  if (w_last) w_state_next = w_next_char ? S_FETCH : S_SETUP;
         default: w_state_next = S_PWRUP;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_init_ptr   <= '0;
         r_init_done  <= 1'b0;
         r_seq        <= '0;
         r_index      <= '0;
         r_data       <= '0;
         r_rs         <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (w_state_next == S_SETUP && r_state != S_SETUP) begin
            if (r_state == S_FETCH) begin
               r_data <= w_char_f;
               r_rs   <= 1'b1;
            end else begin
               r_data <= w_cmd_next;
               r_rs   <= 1'b0;
            end
         end
         if (r_state == S_WAIT && w_last) begin
            if (!r_init_done) begin
               if (r_init_ptr == 2'd3) begin
                  r_init_done <= 1'b1;
                  r_seq       <= '0;
               end else begin
                  r_init_ptr  <= r_init_ptr + 2'd1;
               end
            end else begin
               r_seq        <= w_seq_next;
               r_frame_done <= (r_seq == 6'd33);
            end
            if (w_next_char)
               r_index <= w_char_idx;
         end
      end
   end

   always_comb begin
      lcd_e      = (r_state == S_EHIGH);
      lcd_rs     = r_rs;
      lcd_rw     = 1'b0;
      lcd_data   = r_data;
      index      = r_index;
      init_done  = r_init_done;
      frame_done = r_frame_done;
   end

endmodule

// File: tb/tb_lcd_char_writer.sv
// Randomized self-checking bench for lcd_char_writer: a pulse-level model of the LCD
// command/character stream plus E timing, frame_done and async reset checks.
module tb_lcd_char_writer;

   localparam int POWERUP_CYC = 10;
   localparam int E_PULSE_CYC = 2;
   localparam int CMD_CYC     = 4;
   localparam int CLR_CYC     = 8;
   localparam int FETCH_LAT   = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] char_in = 8'h00;
   logic [4:0] index;
   logic       lcd_e, lcd_rs, lcd_rw, init_done, frame_done;
   logic [7:0] lcd_data;

   int n_total = 0;
   int n_pass  = 0;

   logic [7:0] tab [32];

   // Monitor / model state
   int         pulse_no = 0;
   int         lo_cnt = 0;
   int         hi_cnt = 0;
   int         fd_cnt = 0;
   int         fd_run = 0;
   bit         e_prev = 1'b0;
   bit         m_char;
   bit         m_last_clr = 1'b0;
   int         m_s, m_f, m_idx, m_lit;
   logic [7:0] m_exp;
   int         m_gap;

   lcd_char_writer #(
      .POWERUP_CYC(POWERUP_CYC),
      .E_PULSE_CYC(E_PULSE_CYC),
      .CMD_CYC(CMD_CYC),
      .CLR_CYC(CLR_CYC),
      .FETCH_LAT(FETCH_LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .char_in(char_in),
      .index(index),
      .lcd_e(lcd_e),
      .lcd_rs(lcd_rs),
      .lcd_rw(lcd_rw),
      .lcd_data(lcd_data),
      .init_done(init_done),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Content source: registered lookup of the current index.
   always @(posedge clk) char_in <= tab[index];

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [7:0] filt(input logic [7:0] b);
`ifdef LCD_NONPRINT_FILTER_EN
      return (b < 8'h20 || b > 8'h7E) ? 8'h20 : b;
`else
      return b;
`endif
   endfunction

   // Hand-computed bytes for fixed pulse numbers (default table in frame 0, forced bytes in frame 1).
   function automatic int lit_of(input int k);
      case (k)
         0:  return 'h38;
         1:  return 'h0C;
         2:  return 'h06;
         3:  return 'h01;
         4:  return 'h80;
         5:  return 'h41;
         20: return 'h50;
         21: return 'hC0;
         22: return 'h51;
         37: return 'h60;
         38: return 'h80;
`ifdef LCD_NONPRINT_FILTER_EN
         44: return 'h20;
         45: return 'h20;
`else
         44: return 'h0A;
         45: return 'h7F;
`endif
         default: return -1;
      endcase
   endfunction

   task automatic reset_table();
      for (int i = 0; i < 32; i++) tab[i] = 8'h41 + 8'(i);
   endtask

   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         pulse_no   = 0;
         lo_cnt     = 0;
         hi_cnt     = 0;
         fd_cnt     = 0;
         fd_run     = 0;
         e_prev     = 1'b0;
         m_last_clr = 1'b0;
         reset_table();
      end else begin
         if (lcd_e && !e_prev) begin
            // Model of pulse number pulse_no
            m_char = 1'b0;
            m_idx  = 0;
            if (pulse_no < 4) begin
               case (pulse_no)
                  0: m_exp = 8'h38;
                  1: m_exp = 8'h0C;
                  2: m_exp = 8'h06;
                  default: m_exp = 8'h01;
               endcase
            end else begin
               m_s = (pulse_no - 4) % 34;
               m_f = (pulse_no - 4) / 34;
               if (m_s == 0) begin
                  reset_table();
                  if (m_f == 1) begin
                     tab[5] = 8'h0A;
                     tab[6] = 8'h7F;
                  end else if (m_f >= 2) begin
                     for (int i = 0; i < 32; i++) tab[i] = 8'($urandom_range(0, 255));
                  end
                  if (m_f > 0) check("frame_done_count", fd_cnt, 1);
                  fd_cnt = 0;
                  m_exp = 8'h80;
               end else if (m_s == 17) begin
                  m_exp = 8'hC0;
               end else begin
                  m_char = 1'b1;
                  m_idx  = (m_s < 17) ? m_s - 1 : m_s - 2;
                  m_exp  = filt(tab[m_idx]);
               end
            end
            if (pulse_no == 0) begin
               check("pwrup_idle_in_range", int'(lo_cnt >= POWERUP_CYC && lo_cnt <= POWERUP_CYC + 2), 1);
            end else begin
               m_gap = m_char ? CMD_CYC + FETCH_LAT + 1 : (m_last_clr ? CLR_CYC + 1 : CMD_CYC + 1);
               check("e_low_gap", lo_cnt, m_gap);
            end
            check("lcd_rs", int'(lcd_rs), int'(m_char));
            check("lcd_data", int'(lcd_data), int'(m_exp));
            check("lcd_rw", int'(lcd_rw), 0);
            check("init_done", int'(init_done), int'(pulse_no >= 4));
            if (m_char) check("index", int'(index), m_idx);
            m_lit = lit_of(pulse_no);
            if (m_lit >= 0) check("literal_byte", int'(lcd_data), m_lit);
            $display("pulse %0d rs=%0d data=0x%02h index=%0d init_done=%0d",
                     pulse_no, lcd_rs, lcd_data, index, init_done);
            m_last_clr = !m_char && (m_exp == 8'h01);
            pulse_no++;
            hi_cnt = 1;
         end else if (lcd_e) begin
            hi_cnt++;
         end else if (e_prev) begin
            check("e_high_width", hi_cnt, E_PULSE_CYC);
            lo_cnt = 1;
         end else begin
            lo_cnt++;
         end
         if (frame_done) begin
            if (fd_run == 0)
               check("frame_done_after_idx31",
                     int'(pulse_no >= 38 && ((pulse_no - 5) % 34) == 33 && !lcd_e), 1);
            fd_cnt++;
            fd_run++;
         end else begin
            if (fd_run > 0) check("frame_done_width", fd_run, 1);
            fd_run = 0;
         end
         e_prev = lcd_e;
      end
   end

   task automatic wait_pulses(input int target, input int budget, input string name);
      int n = 0;
      while (pulse_no < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, int'(pulse_no >= target), 1);
   endtask

   initial begin
      int  n;
      bit  found;
      reset_table();
      repeat (3) @(negedge clk);
      check("rst_lcd_e", int'(lcd_e), 0);
      check("rst_lcd_data", int'(lcd_data), 0);
      check("rst_index", int'(index), 0);
      check("rst_init_done", int'(init_done), 0);
      #2 rst = 1'b1;

      wait_pulses(4 + 34 * 4 + 1, 6000, "run_four_frames");

      // Async reset mid-pulse while character 20 is on the bus
      n = 0;
      found = 1'b0;
      while (!found && n < 1000) begin
         @(negedge clk);
         n++;
         if (index == 5'd20 && lcd_e === 1'b1) found = 1'b1;
      end
      check("reach_index20_e_high", int'(found), 1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_lcd_e", int'(lcd_e), 0);
      check("async_rst_lcd_rs", int'(lcd_rs), 0);
      check("async_rst_lcd_rw", int'(lcd_rw), 0);
      check("async_rst_lcd_data", int'(lcd_data), 0);
      check("async_rst_index", int'(index), 0);
      check("async_rst_init_done", int'(init_done), 0);
      check("async_rst_frame_done", int'(frame_done), 0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;

      wait_pulses(4 + 34 * 2 + 1, 2500, "rerun_after_reset");
      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
